// File: rtl/transcription_pkg.sv
// Shared definitions for the transcription chain.
// Holds the FFT geometry, the MIDI note range, the bin-edge table, the note
// tracker state encoding and a guarded table lookup helper.
// NOTE_EDGES[i] is the first FFT bin that belongs to MIDI note NOTE_LO+i.
// NOTE_EDGES[NUM_NOTES] is the first bin above the tracked range.
package transcription_pkg;

  localparam int FS           = 44100;
  localparam int FFT_N        = 4096;
  localparam int NOTE_LO      = 60;
  localparam int NUM_NOTES    = 37;
  localparam int SEARCH_ITERS = 6;
  localparam int EDGE_W       = 8;

  localparam logic [6:0] NOTE_SILENCE = 7'd0;

  // Bin i starts note NOTE_LO+i: ceil(f(note-0.5) * FFT_N / FS).
  localparam logic [EDGE_W-1:0] NOTE_EDGES [0:NUM_NOTES] = '{
    8'd24,  8'd26,  8'd27,  8'd29,  8'd30,  8'd32,  8'd34,  8'd36,
    8'd38,  8'd40,  8'd43,  8'd45,  8'd48,  8'd51,  8'd53,  8'd57,
    8'd60,  8'd64,  8'd67,  8'd71,  8'd75,  8'd80,  8'd85,  8'd90,
    8'd95,  8'd101, 8'd106, 8'd113, 8'd119, 8'd127, 8'd134, 8'd142,
    8'd150, 8'd159, 8'd169, 8'd179, 8'd189, 8'd201
  };

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEARCH   = 3'd1,
    ST_UPDATE   = 3'd2,
    ST_EMIT_OFF = 3'd3,
    ST_EMIT_ON  = 3'd4
  } state_e;

  // Table lookup; out-of-range indices clamp to the upper range edge.
  function automatic logic [EDGE_W-1:0] note_edge(input logic [5:0] idx);
    if (idx > 6'(NUM_NOTES)) begin
      return NOTE_EDGES[NUM_NOTES];
    end else begin
      return NOTE_EDGES[idx];
    end
  endfunction

endpackage

// File: rtl/note_edge_search.sv
// Iterative binary search over the note bin-edge table.
// Finds the largest i with NOTE_EDGES[i] <= bin, one probe per cycle, always
// taking exactly SEARCH_ITERS cycles after start.
// Ports: clk_in/rst_n_in clock and async active-low reset; start_in latches
// bin_in and restarts the search; done_out is high in the cycle whose clock
// edge performs the last probe; index_out is the result (valid once done_out
// has been seen); in_range_out says whether the latched bin lies inside the
// table range [NOTE_EDGES[0], NOTE_EDGES[NUM_NOTES]).
module note_edge_search
  import transcription_pkg::*;
#(
  parameter int BIN_W = 13
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [BIN_W-1:0] bin_in,
  output logic             done_out,
  output logic [5:0]       index_out,
  output logic             in_range_out
);

  localparam int CMP_W = BIN_W + EDGE_W;

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [5:0]       lo_q, lo_d;
  logic [5:0]       hi_q, hi_d;
  logic [2:0]       iter_q, iter_d;
  logic             busy_q, busy_d;
  logic [5:0]       mid_s;
  logic [6:0]       mid_sum_s;

  // Next-state logic: upper-middle probe so the interval always shrinks.
  always_comb begin
    bin_d     = bin_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    iter_d    = iter_q;
    busy_d    = busy_q;
    mid_sum_s = 7'({1'b0, lo_q} + {1'b0, hi_q} + 7'd1);
    mid_s     = mid_sum_s[6:1];
    if (start_in) begin
      bin_d  = bin_in;
      lo_d   = 6'd0;
      hi_d   = 6'(NUM_NOTES - 1);
      iter_d = 3'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Once converged the remaining iterations are no-ops; latency stays fixed.
      if (lo_q != hi_q) begin
        if (CMP_W'(note_edge(mid_s)) <= CMP_W'(bin_q)) begin
          lo_d = mid_s;
        end else begin
          hi_d = mid_s - 6'd1;
        end
      end else begin
        lo_d = lo_q;
      end
      iter_d = iter_q + 3'd1;
      if (iter_q == 3'(SEARCH_ITERS - 1)) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Search state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bin_q  <= '0;
      lo_q   <= 6'd0;
      hi_q   <= 6'd0;
      iter_q <= 3'd0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end

  assign done_out     = busy_q && (iter_q == 3'(SEARCH_ITERS - 1));
  assign index_out    = lo_q;
  assign in_range_out = (CMP_W'(bin_q) >= CMP_W'(NOTE_EDGES[0])) &&
                        (CMP_W'(bin_q) <  CMP_W'(NOTE_EDGES[NUM_NOTES]));

endmodule

// File: rtl/note_tracker.sv
// Maps one dominant FFT bin per frame to a MIDI note, debounces it across
// STABLE_FRAMES identical frame results and emits note-off / note-on events
// on a valid/ready handshake.
// Ports: clk_in, rst_n_in (async active-low); peak_bin_in/peak_valid_in frame
// input strobe; note_out/note_on_out/event_valid_out/event_ready_in event
// channel; current_note_out sounding note (0 = silence); overrun_out sticky
// flag for strobes that arrived while the tracker was busy.
module note_tracker
  import transcription_pkg::*;
#(
  parameter int BIN_W         = 13,
  parameter int STABLE_FRAMES = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [BIN_W-1:0] peak_bin_in,
  input  logic             peak_valid_in,
  output logic [6:0]       note_out,
  output logic             note_on_out,
  output logic             event_valid_out,
  input  logic             event_ready_in,
  output logic [6:0]       current_note_out,
  output logic             overrun_out
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_FRAMES);

  state_e     state_q, state_d;
  logic [6:0] pending_q, pending_d;
  logic [3:0] count_q, count_d;
  logic [6:0] current_q, current_d;
  logic [6:0] note_q, note_d;
  logic       note_on_q, note_on_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  logic       search_start_s;
  logic       search_done_s;
  logic [5:0] index_s;
  logic       in_range_s;
  logic [6:0] cand_s;
  logic [6:0] pending_next_s;
  logic [3:0] count_next_s;
  logic       handshake_s;

  assign search_start_s = (state_q == ST_IDLE) && peak_valid_in;

  note_edge_search #(
    .BIN_W (BIN_W)
  ) u_search (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (search_start_s),
    .bin_in       (peak_bin_in),
    .done_out     (search_done_s),
    .index_out    (index_s),
    .in_range_out (in_range_s)
  );

  // Next-state and registered-output logic of the tracking FSM.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    count_d     = count_q;
    current_d   = current_q;
    note_d      = note_q;
    note_on_d   = note_on_q;
    valid_d     = valid_q;
    handshake_s = valid_q && event_ready_in;
    overrun_d   = overrun_q | (peak_valid_in && (state_q != ST_IDLE));

    cand_s = in_range_s ? (7'(NOTE_LO) + {1'b0, index_s}) : NOTE_SILENCE;
    // Saturating debounce counter: a held note never re-triggers.
    if (cand_s == pending_q) begin
      pending_next_s = pending_q;
      count_next_s   = (count_q >= STABLE_C) ? STABLE_C : (count_q + 4'd1);
    end else begin
      pending_next_s = cand_s;
      count_next_s   = 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (peak_valid_in) begin
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (search_done_s) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_UPDATE: begin
        pending_d = pending_next_s;
        count_d   = count_next_s;
        if ((count_next_s == STABLE_C) && (pending_next_s != current_q)) begin
          valid_d = 1'b1;
          if (current_q != NOTE_SILENCE) begin
            state_d   = ST_EMIT_OFF;
            note_d    = current_q;
            note_on_d = 1'b0;
          end else begin
            state_d   = ST_EMIT_ON;
            note_d    = pending_next_s;
            note_on_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT_OFF: begin
        if (handshake_s) begin
          current_d = pending_q;
          // Going to silence needs no note-on.
          if (pending_q != NOTE_SILENCE) begin
            state_d   = ST_EMIT_ON;
            note_d    = pending_q;
            note_on_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end else begin
          state_d = ST_EMIT_OFF;
        end
      end
      ST_EMIT_ON: begin
        if (handshake_s) begin
          current_d = pending_q;
          valid_d   = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_EMIT_ON;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      pending_q <= NOTE_SILENCE;
      count_q   <= 4'd0;
      current_q <= NOTE_SILENCE;
      note_q    <= 7'd0;
      note_on_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      current_q <= current_d;
      note_q    <= note_d;
      note_on_q <= note_on_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign note_out         = note_q;
  assign note_on_out      = note_on_q;
  assign event_valid_out  = valid_q;
  assign current_note_out = current_q;
  assign overrun_out      = overrun_q;

endmodule

// File: doc/note_tracker.md
# note_tracker

Downstream consumer of the FFT peak finder. Takes one dominant-bin index per FFT frame and maps it to a MIDI note number using a bin-edge table. It debounces the note across consecutive frames and emits note-on/note-off events over a valid/ready handshake. The transcription back end (MIDI/UART formatter, display) consumes these events.

## Interface
- `BIN_W`, 13, width of the incoming bin index.
- `STABLE_FRAMES`, 3, number of consecutive identical frame results required before the tracked note changes (range 1..15).
- `clk_in`  input  1  system clock.
- `rst_n_in`  input  1  asynchronous active-low reset; all state cleared while low.
- `peak_bin_in`  input  BIN_W  dominant FFT bin index for the current frame.
- `peak_valid_in`  input  1  single-cycle strobe; `peak_bin_in` is valid this cycle.
- `note_out`  output  7  MIDI note carried by the current event; reset 0.
- `note_on_out`  output  1  1 = note-on, 0 = note-off, qualified by `event_valid_out`; reset 0.
- `event_valid_out`  output  1  event pending; reset 0.
- `event_ready_in`  input  1  consumer accepts the event when high together with `event_valid_out`.
- `current_note_out`  output  7  currently sounding note, 0 = silence; reset 0.
- `overrun_out`  output  1  sticky flag: a peak strobe arrived while busy; reset 0, cleared only by reset.

## Operation
- FSM states: IDLE, SEARCH, UPDATE, EMIT_OFF, EMIT_ON.
- IDLE:
  - On `peak_valid_in`, latch the bin, set lo=0 and hi=NUM_NOTES-1, go to SEARCH.
  - A strobe in any other state is dropped and sets `overrun_out`.
- SEARCH runs exactly 6 iterations (ceil log2 37), one per cycle, regardless of input.
  - Binary search for the largest i with NOTE_EDGES[i] <= bin.
  - Candidate = NOTE_LO + i.
  - Candidate is forced to 0 (silence) if bin < NOTE_EDGES[0] or bin >= NOTE_EDGES[NUM_NOTES].
- UPDATE (1 cycle):
  - Candidate == pending: count = min(count+1, STABLE_FRAMES).
  - Candidate != pending: pending = candidate, count = 1.
  - If count reaches STABLE_FRAMES this cycle and pending != `current_note_out`:
    - Current note nonzero: go to EMIT_OFF.
    - Current note zero: go to EMIT_ON.
  - Otherwise return to IDLE.
- EMIT_OFF: `note_out` = old current note, `note_on_out` = 0. On handshake:
  - Update current note to pending.
  - Go to EMIT_ON if pending is nonzero, else go to IDLE.
- EMIT_ON: `note_out` = pending, `note_on_out` = 1. On handshake:
  - Set current note = pending.
  - Go to IDLE.
- `note_out` and `note_on_out` stay stable while `event_valid_out` is high and `event_ready_in` is low.
- Count saturates, so a held note never re-triggers.
- STABLE_FRAMES=1 means every changed frame result produces events immediately.

## Timing
- All outputs are registered.
- Event latency, measured from the edge that samples `peak_valid_in`:
  - `event_valid_out` rises after the 8th edge (edge 1: IDLE→SEARCH, edges 2-7: SEARCH, edge 8: UPDATE).
  - Latency is fixed, including for silence results.
- Back-to-back events (off then on) with `event_ready_in` tied high: `event_valid_out` stays high for two consecutive cycles.
- Earliest re-acceptance of a strobe:
  - Cycle after returning to IDLE.
  - Minimum frame spacing without overrun is 9 cycles with ready held high.
- Reset asserted mid-operation: all outputs and state drop asynchronously to reset values; any pending event is discarded.
- Handshake while `event_valid_out` is low has no effect.

## Structure
- Shared package `transcription_pkg` holds:
  - FS=44100 and FFT_N=4096.
  - NOTE_LO=60 and NUM_NOTES=37 (MIDI 60..96).
  - NOTE_SILENCE=7'd0.
  - NOTE_EDGES[0:NUM_NOTES], where NOTE_EDGES[i] = ceil(f(NOTE_LO+i-0.5)·FFT_N/FS) and f(n) = 440·2^((n-69)/12). This gives NOTE_EDGES[0]=24 and NOTE_EDGES[37]=201; A4 occupies bins 40..42.
  - The FSM state enum.
- Sub-module `note_edge_search`:
  - Iterative binary search; start/bin in, done/index/in-range out.
  - Instantiated once; owns the table lookup.

## Test plan
- Reset, then STABLE_FRAMES=3 and bin 41 strobed 3 times at 20-cycle spacing:
  - Exactly one event: note_on=1, note=69, valid 8 edges after 3rd strobe.
  - `current_note_out`=69.
- Then 3 frames of bin 10 (below range): one note_off for note 69, `current_note_out`=0.
- Note 69 held, then 3 frames of bin 24: note_off 69 then note_on 60, back-to-back.
  - With `event_ready_in` low for 5 cycles, outputs are held stable until ready rises.
- Alternating bins 41/24 for 10 frames: no events (count never reaches 3).
  - Then 4 more frames of bin 41: single note_on 69 only.
- Boundaries: bins 23, 24, 200, 201 → candidates 0, 60, 96, 0.
  - Check via STABLE_FRAMES=1 events.
- Strobe 4 cycles after a previous strobe: `overrun_out`=1 and the second frame is ignored.
- `rst_n_in` pulsed low while `event_valid_out` is high: all outputs 0 immediately; no event after release.
